bcd_counter_sequencer: RTL and testbench

Controller that sequences the single-digit bidirectional 0–9 counter. It generates that counter's `enable`, `direction` and clear controls from start, stop and direction-toggle commands, and paces steps with an internal tick prescaler. It sits between the user command synchronisers/debouncers and the counter datapath, and reads the counter's value back to detect terminal digits.

---
 rtl/bcd_seq_pkg.sv | 31 +++
 rtl/bcd_counter_sequencer_if.sv | 31 +++
 rtl/tick_prescaler.sv | 34 +++
 rtl/bcd_counter_sequencer.sv | 129 ++++++++++++
 tb/tb_bcd_counter_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_seq_pkg.sv
// bcd_seq_pkg
// Shared types and constants for the BCD counter sequencer.
//   seq_state_t          : FSM state encoding (IDLE=0, RUN=1, PAUSE=2)
//   DIGIT_MIN/DIGIT_MAX  : legal digit range of the controlled counter
//   DIR_UP/DIR_DOWN      : cnt_direction encodings
//   next_digit()         : value the counter takes after one step
package bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } seq_state_t;

    localparam logic [3:0] DIGIT_MIN = 4'd0;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Out-of-range values are returned unchanged so they can never look
    // like a terminal or reversal digit.
    function automatic logic [3:0] next_digit(input logic [3:0] q, input logic dir);
        if (q > DIGIT_MAX)
            return q;
        if (dir == DIR_UP)
            return (q == DIGIT_MAX) ? DIGIT_MIN : q + 4'd1;
        return (q == DIGIT_MIN) ? DIGIT_MAX : q - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_counter_sequencer_if.sv
// bcd_seq_if
// Command and counter-control bundle of the BCD counter sequencer.
//   start, stop, dir_toggle : one-cycle command pulses
//   mode_down               : initial direction for a start from IDLE
//   q_in[3:0]               : counter value fed back
//   cnt_enable, cnt_direction, cnt_clear : counter controls
//   running, wrap, state[1:0]            : status
// master: command/counter side. slave: the sequencer.
interface bcd_seq_if;
    logic       start;
    logic       stop;
    logic       dir_toggle;
    logic       mode_down;
    logic [3:0] q_in;
    logic       cnt_enable;
    logic       cnt_direction;
    logic       cnt_clear;
    logic       running;
    logic       wrap;
    logic [1:0] state;

    modport master (
        output start, stop, dir_toggle, mode_down, q_in,
        input  cnt_enable, cnt_direction, cnt_clear, running, wrap, state
    );

    modport slave (
        input  start, stop, dir_toggle, mode_down, q_in,
        output cnt_enable, cnt_direction, cnt_clear, running, wrap, state
    );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Step pacing counter: counts 0..TICK_DIV-1 while run=1 and flags the
// terminal count with a one-cycle tick (combinational, same cycle).
//   clki    : clock
//   reset_n : async active-low reset
//   run     : advance the count; when low the count holds
//   clr     : synchronous clear to zero
//   tick    : high while run=1 and the count is at TICK_DIV-1
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clki,
    input  logic reset_n,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (run)
            count <= tick ? '0 : count + ONE;
    end
endmodule

// File: rtl/bcd_counter_sequencer.sv
// bcd_counter_sequencer
// Sequences a single-digit 0-9 up/down counter from start/stop/toggle
// commands, pacing steps with tick_prescaler (TICK_DIV cycles per step).
//   clki    : clock
//   reset_n : async active-low reset
//   bus     : bcd_seq_if.slave (commands in, counter controls/status out)
// Optional build macro BCD_SEQ_PINGPONG_EN: bounce 0..9..0 instead of
// wrapping; wrap then flags the reversal steps (from 8 up / from 1 down).
//
//  state | meaning
//  IDLE  | stopped, prescaler cleared, waiting for start
//  RUN   | prescaler advancing, counter stepped on every tick
//  PAUSE | stopped, prescaler value held for resume
module bcd_counter_sequencer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic     clki,
    input  logic     reset_n,
    bcd_seq_if.slave bus
);
    import bcd_seq_pkg::*;

    seq_state_t state_q, state_d;
    logic       dir_q, dir_d;
    logic       clear_q, clear_d;
    logic       enable_q, wrap_q, running_q;
    logic       presc_run, presc_clr, tick;
    logic [3:0] q_eff;
    logic       step_hit;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clki    (clki),
        .reset_n (reset_n),
        .run     (presc_run),
        .clr     (presc_clr),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        clear_d   = 1'b0;
        presc_run = 1'b0;
        presc_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    dir_d     = bus.mode_down;
                    clear_d   = 1'b1;
                    presc_clr = 1'b1;
                end
            end
            RUN: begin
                // stop freezes the prescaler this edge, which also
                // suppresses a tick that would otherwise land now
                if (bus.stop)
                    state_d = PAUSE;
                else begin
                    presc_run = 1'b1;
                    if (!bus.start && bus.dir_toggle)
                        dir_d = ~dir_q;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_d   = IDLE;
                    presc_clr = 1'b1;
                end else if (bus.start)
                    state_d = RUN;
                else if (bus.dir_toggle)
                    dir_d = ~dir_q;
            end
            default: begin
                state_d   = IDLE;
                presc_clr = 1'b1;
            end
        endcase
`ifdef BCD_SEQ_PINGPONG_EN
        // wrap_q marks the reversal step just issued; a coincident
        // manual toggle has already flipped dir_d, so the two cancel
        if (wrap_q)
            dir_d = ~dir_d;
`endif
    end

    // q_in still shows the pre-step value if the counter is being cleared
    // or stepped on this same edge (TICK_DIV=1); look ahead so wrap lines
    // up with the value the counter holds while the new pulse is out.
    always_comb begin
        q_eff = bus.q_in;
        if (clear_q)
            q_eff = (dir_q == DIR_DOWN) ? DIGIT_MAX : DIGIT_MIN;
        else if (enable_q)
            q_eff = next_digit(bus.q_in, dir_q);
`ifdef BCD_SEQ_PINGPONG_EN
        step_hit = ((dir_d == DIR_UP)   && (q_eff == DIGIT_MAX - 4'd1)) ||
                   ((dir_d == DIR_DOWN) && (q_eff == DIGIT_MIN + 4'd1));
`else
        step_hit = ((dir_d == DIR_UP)   && (q_eff == DIGIT_MAX)) ||
                   ((dir_d == DIR_DOWN) && (q_eff == DIGIT_MIN));
`endif
    end

    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            clear_q   <= 1'b0;
            enable_q  <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            clear_q   <= clear_d;
            enable_q  <= tick;
            wrap_q    <= tick && step_hit;
            running_q <= (state_d == RUN);
        end
    end

    assign bus.cnt_enable    = enable_q;
    assign bus.cnt_direction = dir_q;
    assign bus.cnt_clear     = clear_q;
    assign bus.running       = running_q;
    assign bus.wrap          = wrap_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_bcd_counter_sequencer.sv
// tb_bcd_counter_sequencer
// Directed bench for bcd_counter_sequencer with TICK_DIV=4, a 0-9
// counter model on q_in and a command-level reference model checked on
// every cycle, plus hand-computed expectations per scenario.
module tb_bcd_counter_sequencer;
    localparam int TD = 4;

`ifdef BCD_SEQ_PINGPONG_EN
    localparam int EXP1 [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8};
    localparam int W1 = 8;
    localparam int EXP2 [10] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    localparam int W2 = 1;
    localparam int EXP5 [20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8,
                                 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
`else
    localparam int EXP1 [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    localparam int W1 = 9;
    localparam int EXP2 [10] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
    localparam int W2 = 0;
`endif

    logic clki    = 1'b0;
    logic reset_n = 1'b1;

    bcd_seq_if bus ();

    bcd_counter_sequencer #(.TICK_DIV(TD)) dut (
        .clki    (clki),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clki = ~clki;

    // reference model: mode 0=idle 1=run 2=pause, presc = cycles into step
    typedef struct {
        int mode;
        int presc;
        bit dir;
        bit en;
        bit clr;
    } model_t;

    model_t     m;
    logic [3:0] q_model;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         en_count = 0;
    int         wrap_count = 0;
    int         last_en_cyc = 0;
    int         wrap_at = 0;
    bit         pend_step = 1'b0;
    int         steps_q [$];
    int         start_cyc, first_en, resume_cyc, e0, e1, w0;

    function automatic bit is_term(input int q, input bit dir);
        return dir ? (q == 0) : (q == 9);
    endfunction

    function automatic bit is_rev(input int q, input bit dir);
        return dir ? (q == 1) : (q == 8);
    endfunction

    function automatic bit wrap_rule(input int q, input bit dir);
`ifdef BCD_SEQ_PINGPONG_EN
        return is_rev(q, dir);
`else
        return is_term(q, dir);
`endif
    endfunction

    function automatic model_t model_step(input model_t cur, input bit s, input bit p,
                                          input bit t, input bit md, input int q);
        model_t n = cur;
        n.en  = 1'b0;
        n.clr = 1'b0;
        if (cur.mode == 0) begin
            if (s) begin
                n.mode = 1; n.dir = md; n.clr = 1'b1; n.presc = 0;
            end
        end else if (cur.mode == 1) begin
            if (p)
                n.mode = 2;
            else begin
                if (cur.presc == TD - 1) begin
                    n.presc = 0; n.en = 1'b1;
                end else
                    n.presc = cur.presc + 1;
                if (!s && t)
                    n.dir = !cur.dir;
            end
        end else begin
            if (p) begin
                n.mode = 0; n.presc = 0;
            end else if (s)
                n.mode = 1;
            else if (t)
                n.dir = !cur.dir;
        end
`ifdef BCD_SEQ_PINGPONG_EN
        if (cur.en && is_rev(q, cur.dir))
            n.dir = !n.dir;
`endif
        return n;
    endfunction

    always @(posedge clki or negedge reset_n) begin
        if (!reset_n)
            m <= '{0, 0, 1'b0, 1'b0, 1'b0};
        else
            m <= model_step(m, bus.start, bus.stop, bus.dir_toggle, bus.mode_down,
                            int'(q_model));
    end

    always @(posedge clki or negedge reset_n) begin
        if (!reset_n)
            q_model <= 4'd0;
        else if (bus.cnt_clear)
            q_model <= bus.cnt_direction ? 4'd9 : 4'd0;
        else if (bus.cnt_enable) begin
            if (!bus.cnt_direction)
                q_model <= (q_model == 4'd9) ? 4'd0 : q_model + 4'd1;
            else
                q_model <= (q_model == 4'd0) ? 4'd9 : q_model - 4'd1;
        end
    end

    assign bus.q_in = q_model;

    always @(posedge clki) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clki);
        if (reset_n) begin
            if (pend_step)
                steps_q.push_back(int'(q_model));
            pend_step = bus.cnt_enable;
            chk("cnt_enable", int'(bus.cnt_enable), int'(m.en));
            chk("cnt_direction", int'(bus.cnt_direction), int'(m.dir));
            chk("cnt_clear", int'(bus.cnt_clear), int'(m.clr));
            chk("running", int'(bus.running), int'(m.mode == 1));
            chk("state", int'(bus.state), m.mode);
            chk("wrap", int'(bus.wrap), int'(m.en && wrap_rule(int'(q_model), m.dir)));
            if (bus.cnt_enable) begin
                en_count++;
                last_en_cyc = cyc;
            end
            if (bus.wrap) begin
                wrap_count++;
                wrap_at = int'(q_model);
            end
        end else
            pend_step = 1'b0;
    endtask

    task automatic wait_steps(input int target, input int limit);
        int n = 0;
        while (en_count < target && n < limit) begin
            next_cycle();
            n++;
        end
        if (en_count < target) begin
            checks++;
            errors++;
            $display("FAIL step_timeout: got %0d steps, expected %0d", en_count, target);
        end
    endtask

    task automatic cmd(input bit s, input bit p, input bit t);
        next_cycle();
        bus.start = s; bus.stop = p; bus.dir_toggle = t;
        next_cycle();
        bus.start = 1'b0; bus.stop = 1'b0; bus.dir_toggle = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_enable"}, int'(bus.cnt_enable), 0);
        chk({tag, "_direction"}, int'(bus.cnt_direction), 0);
        chk({tag, "_clear"}, int'(bus.cnt_clear), 0);
        chk({tag, "_running"}, int'(bus.running), 0);
        chk({tag, "_wrap"}, int'(bus.wrap), 0);
        chk({tag, "_state"}, int'(bus.state), 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.dir_toggle = 1'b0; bus.mode_down = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) next_cycle();
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) next_cycle();

        // count up from a clear
        bus.mode_down = 1'b0;
        cmd(1'b1, 1'b0, 1'b0);
        chk("s1_clear", int'(bus.cnt_clear), 1);
        chk("s1_running", int'(bus.running), 1);
        start_cyc = cyc; steps_q.delete(); e0 = en_count; w0 = wrap_count;
        wait_steps(e0 + 1, 20);
        first_en = last_en_cyc;
        chk("s1_first_latency", first_en - start_cyc, 4);
        wait_steps(e0 + 10, 60);
        chk("s1_ten_span", last_en_cyc - first_en, 36);
        next_cycle();
        chk("s1_step_count", steps_q.size(), 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("s1_step%0d", i), steps_q[i], EXP1[i]);
        chk("s1_final_q", int'(q_model), EXP1[9]);
        chk("s1_wraps", wrap_count - w0, 1);
        chk("s1_wrap_q", wrap_at, W1);
        cmd(1'b0, 1'b1, 1'b0);
        chk("s1_pause", int'(bus.state), 2);
        cmd(1'b0, 1'b1, 1'b0);
        chk("s1_idle", int'(bus.state), 0);

        // count down from a clear to 9
        bus.mode_down = 1'b1;
        cmd(1'b1, 1'b0, 1'b0);
        chk("s2_clear", int'(bus.cnt_clear), 1);
        chk("s2_direction", int'(bus.cnt_direction), 1);
        steps_q.delete(); e0 = en_count; w0 = wrap_count;
        wait_steps(e0 + 10, 60);
        next_cycle();
        for (int i = 0; i < 10; i++)
            chk($sformatf("s2_step%0d", i), steps_q[i], EXP2[i]);
        chk("s2_wraps", wrap_count - w0, 1);
        chk("s2_wrap_q", wrap_at, W2);
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);
        chk("s2_idle", int'(bus.state), 0);

        // pause with prescaler at 2, resume without clear
        bus.mode_down = 1'b0;
        cmd(1'b1, 1'b0, 1'b0);
        e0 = en_count;
        next_cycle();
        cmd(1'b0, 1'b1, 1'b0);
        chk("s3_paused", int'(bus.state), 2);
        chk("s3_no_step_before_stop", en_count, e0);
        e1 = en_count;
        repeat (20) next_cycle();
        chk("s3_no_step_in_pause", en_count, e1);
        cmd(1'b1, 1'b0, 1'b0);
        resume_cyc = cyc;
        chk("s3_resume_clear", int'(bus.cnt_clear), 0);
        chk("s3_resume_running", int'(bus.running), 1);
        wait_steps(e1 + 1, 20);
        chk("s3_resume_latency", last_en_cyc - resume_cyc, 2);
        cmd(1'b0, 1'b1, 1'b0);
        chk("s3_pause2", int'(bus.state), 2);
        cmd(1'b0, 1'b1, 1'b0);
        chk("s3_idle", int'(bus.state), 0);

        // toggle on the tick edge at q=5, then start+stop together
        bus.mode_down = 1'b0;
        cmd(1'b1, 1'b0, 1'b0);
        e0 = en_count;
        wait_steps(e0 + 5, 40);
        repeat (2) next_cycle();
        cmd(1'b0, 1'b0, 1'b1);
        chk("s4_coincident_enable", int'(bus.cnt_enable), 1);
        chk("s4_coincident_dir", int'(bus.cnt_direction), 1);
        next_cycle();
        chk("s4_stepped_to", int'(q_model), 4);
        cmd(1'b1, 1'b1, 1'b0);
        chk("s4_start_stop_pause", int'(bus.state), 2);
        cmd(1'b0, 1'b1, 1'b0);
        chk("s4_idle", int'(bus.state), 0);

`ifdef BCD_SEQ_PINGPONG_EN
        // ping-pong over twenty steps
        bus.mode_down = 1'b0;
        cmd(1'b1, 1'b0, 1'b0);
        steps_q.delete(); e0 = en_count; w0 = wrap_count;
        wait_steps(e0 + 20, 120);
        next_cycle();
        for (int i = 0; i < 20; i++)
            chk($sformatf("s5_step%0d", i), steps_q[i], EXP5[i]);
        chk("s5_wraps", wrap_count - w0, 2);
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);
`endif

        // reset in the middle of a step pulse
        bus.mode_down = 1'b0;
        cmd(1'b1, 1'b0, 1'b0);
        e0 = en_count;
        wait_steps(e0 + 1, 20);
        chk("s6_pulse_live", int'(bus.cnt_enable), 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("s6_reset");
        repeat (2) next_cycle();
        reset_n = 1'b1;
        next_cycle();
        cmd(1'b1, 1'b0, 1'b0);
        chk("s6_clear", int'(bus.cnt_clear), 1);
        chk("s6_running", int'(bus.running), 1);
        start_cyc = cyc; e0 = en_count;
        wait_steps(e0 + 1, 20);
        chk("s6_first_latency", last_en_cyc - start_cyc, 4);
        repeat (2) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
